// File: rtl/control_fsm.sv
// Multicycle sequencing FSM: commit strobes, memory handshake and trap control.
// Build option ILLEGAL_INSN_TRAP_EN: illegal encodings trap (cause 2) instead of acting as NOPs.
module control_fsm #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [11:0] funct12,
    input  logic        irq,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        alu_out_we,
    output logic        mdr_we,
    output logic        rf_we,
    output logic        csr_we,
    output logic        pc_we,
    output logic        trap_pending,
    output logic        trap_finish,
    output logic [4:0]  trap_cause,
    output logic        retire
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_TRAP    = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic        TO_EN   = (MEM_TIMEOUT != 0);

    logic [2:0]  state_q, state_d;
    logic        entry_q;
    logic [15:0] cnt_q;
    logic [4:0]  cause_q, cause_d;

    logic req_c, we_c, asel_c, irw_c, aluw_c, mdrw_c;
    logic rfw_c, csrw_c, pcw_c, tp_c, tf_c, ret_c;
    logic illegal;
    logic to_hit;
    logic is_store;
    logic is_system;

    assign is_store  = (opcode == OPC_STORE);
    assign is_system = (opcode == OPC_SYSTEM);
    assign to_hit    = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        req_c   = 1'b0;
        we_c    = 1'b0;
        asel_c  = 1'b0;
        irw_c   = 1'b0;
        aluw_c  = 1'b0;
        mdrw_c  = 1'b0;
        rfw_c   = 1'b0;
        csrw_c  = 1'b0;
        pcw_c   = 1'b0;
        tp_c    = 1'b0;
        tf_c    = 1'b0;
        ret_c   = 1'b0;
        illegal = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                // irq is sampled only before the request goes out
                if (entry_q && irq) begin
                    state_d = S_TRAP;
                    cause_d = 5'b1_1011;
                end else begin
                    req_c = 1'b1;
                    if (mem_ack) begin
                        irw_c   = 1'b1;
                        state_d = S_DECODE;
                    end else if (to_hit) begin
                        state_d = S_TRAP;
                        cause_d = 5'd1;
                    end
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                aluw_c = 1'b1;
                unique case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = S_MEM;
                    OPC_OP, OPC_OP_IMM, OPC_LUI,
                    OPC_AUIPC, OPC_JAL, OPC_JALR: state_d = S_WB;
                    OPC_BRANCH: begin
                        pcw_c   = 1'b1;
                        ret_c   = 1'b1;
                        state_d = S_FETCH;
                    end
                    OPC_SYSTEM: begin
                        if (func3 == 3'b000) begin
                            unique case (funct12)
                                12'h000: begin
                                    state_d = S_TRAP;
                                    cause_d = 5'd11;
                                end
                                12'h001: begin
                                    state_d = S_TRAP;
                                    cause_d = 5'd3;
                                end
                                12'h302: begin
                                    tf_c    = 1'b1;
                                    pcw_c   = 1'b1;
                                    ret_c   = 1'b1;
                                    state_d = S_FETCH;
                                end
                                default: illegal = 1'b1;
                            endcase
                        end else if (func3 != 3'b100) begin
                            state_d = S_WB;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
                if (illegal) begin
`ifdef ILLEGAL_INSN_TRAP_EN
                    state_d = S_TRAP;
                    cause_d = 5'd2;
`else
                    pcw_c   = 1'b1;
                    ret_c   = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_MEM: begin
                req_c  = 1'b1;
                asel_c = 1'b1;
                we_c   = is_store;
                if (mem_ack) begin
                    if (is_store) begin
                        pcw_c   = 1'b1;
                        ret_c   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdrw_c  = 1'b1;
                        state_d = S_WB;
                    end
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = is_store ? 5'd7 : 5'd5;
                end
            end
            S_WB: begin
                // csr_we also commits rd for Zicsr, keeping rf_we/csr_we exclusive
                csrw_c  = is_system;
                rfw_c   = !is_system;
                pcw_c   = 1'b1;
                ret_c   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                tp_c    = 1'b1;
                pcw_c   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            entry_q <= 1'b1;
            cnt_q   <= 16'd0;
            cause_q <= 5'd0;
        end else begin
            state_q <= state_d;
            entry_q <= (state_d != state_q);
            cause_q <= cause_d;
            if (state_d != state_q)
                cnt_q <= 16'd0;
            else if (req_c && !mem_ack)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign mem_req      = !rst && req_c;
    assign mem_we       = !rst && we_c;
    assign mem_addr_sel = !rst && asel_c;
    assign ir_we        = !rst && irw_c;
    assign alu_out_we   = !rst && aluw_c;
    assign mdr_we       = !rst && mdrw_c;
    assign rf_we        = !rst && rfw_c;
    assign csr_we       = !rst && csrw_c;
    assign pc_we        = !rst && pcw_c;
    assign trap_pending = !rst && tp_c;
    assign trap_finish  = !rst && tf_c;
    assign retire       = !rst && ret_c;
    assign trap_cause   = (!rst && state_q == S_TRAP) ? cause_q : 5'd0;

endmodule
